pc_fetch_stage: RTL

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

---
 rtl/pc_fetch_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - instruction fetch PC generator with IF/ID pipeline register
//
// Purpose: holds the fetch PC, selects the next PC from redirect / hold /
// sequential, and latches the fetched instruction into the IF/ID register.
// A BOOT -> RUN -> TRAP state machine runs the sequence. A misaligned
// redirect traps the stage until reset.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   PcSel, BrPC    redirect request and its target address
//   Stall          hold request for the PC and the IF/ID register
//   Instr_In       instruction memory data for the current PC (same cycle)
//   PC             current fetch address (registered)
//   IfId_PC/Instr/Valid  IF/ID register contents
//   Misalign       sticky misaligned-redirect trap flag
//   RedirectCount  saturating count of accepted redirects
//                  (present only when FETCH_REDIRECT_CNT_EN is defined)

module pc_fetch_stage #(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Stall,
  input  logic [31:0]     Instr_In,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] IfId_PC,
  output logic [31:0]     IfId_Instr,
  output logic            IfId_Valid,
  output logic            Misalign
`ifdef FETCH_REDIRECT_CNT_EN
  ,
  output logic [15:0]     RedirectCount
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            misalign_q, misalign_d;
`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0]     cnt_q, cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    misalign_d   = misalign_q;
`ifdef FETCH_REDIRECT_CNT_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      BOOT: begin
        // One cycle with PC at 0 and a bubble; PcSel/Stall are ignored.
        state_d      = RUN;
        pc_d         = '0;
        ifid_pc_d    = '0;
        ifid_instr_d = NOP;
        ifid_valid_d = 1'b0;
      end

      RUN: begin
        if (PcSel) begin
          // A redirect always squashes IF/ID, overriding Stall.
          ifid_pc_d    = '0;
          ifid_instr_d = NOP;
          ifid_valid_d = 1'b0;
          if (BrPC[1:0] == 2'b00) begin
            // Target is truncated to the fetch address width.
            pc_d = PC_W'(BrPC);
`ifdef FETCH_REDIRECT_CNT_EN
            if (cnt_q != 16'hFFFF) begin
              cnt_d = cnt_q + 16'd1;
            end
`endif
          end else begin
            state_d    = TRAP;
            misalign_d = 1'b1;
          end
        end else if (!Stall) begin
          pc_d         = pc_q + PC_W'(4);
          ifid_pc_d    = pc_q;
          ifid_instr_d = Instr_In;
          ifid_valid_d = 1'b1;
        end
      end

      TRAP: begin
        // Absorbing: everything frozen, bubble and flag held.
        ifid_pc_d    = '0;
        ifid_instr_d = NOP;
        ifid_valid_d = 1'b0;
        misalign_d   = 1'b1;
      end

      default: begin
        state_d      = BOOT;
        pc_d         = '0;
        ifid_pc_d    = '0;
        ifid_instr_d = NOP;
        ifid_valid_d = 1'b0;
        misalign_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
`ifdef FETCH_REDIRECT_CNT_EN
      cnt_q        <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
`ifdef FETCH_REDIRECT_CNT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign PC         = pc_q;
  assign IfId_PC    = ifid_pc_q;
  assign IfId_Instr = ifid_instr_q;
  assign IfId_Valid = ifid_valid_q;
  assign Misalign   = misalign_q;
`ifdef FETCH_REDIRECT_CNT_EN
  assign RedirectCount = cnt_q;
`endif

endmodule
